// File: rtl/r2mdc_stage_ctrl_if.sv
// Handshake bundle between an R2MDC stage sequencer and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the pair stream is push-only, one pair per in_valid cycle.
// Ports:
//   in_valid/in_start            : pair strobe and first-pair-of-frame qualifier
//   tw_addr                      : twiddle ROM address
//   dl_en/sw_sel                 : delay-line shift enable, commutator select
//   out_valid/out_start/out_last : output pair strobes toward the next stage
//   busy/frame_err               : status
interface r2mdc_stage_ctrl_if #(
  parameter int TW_AW = 3
);
  logic             in_valid;
  logic             in_start;
  logic [TW_AW-1:0] tw_addr;
  logic             dl_en;
  logic             sw_sel;
  logic             out_valid;
  logic             out_start;
  logic             out_last;
  logic             busy;
  logic             frame_err;

  // upstream / environment side
  modport master (
    output in_valid, in_start,
    input  tw_addr, dl_en, sw_sel, out_valid, out_start, out_last, busy, frame_err
  );

  // sequencer side
  modport slave (
    input  in_valid, in_start,
    output tw_addr, dl_en, sw_sel, out_valid, out_start, out_last, busy, frame_err
  );
endinterface

// File: rtl/r2mdc_stage_ctrl.sv
// Sequencer for one R2MDC FFT stage: twiddle address, delay-line enable, commutator select, output strobes.
// Latency: every output is registered, one cycle after the pair (or flush cycle) it describes.
// Backpressure: none; in_valid=0 is a stall, and the first out_valid follows DC delay-line shifts.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus.slave  : in_valid/in_start in; tw_addr, dl_en, sw_sel, out_valid,
//                out_start, out_last, busy, frame_err out
module r2mdc_stage_ctrl #(
  parameter int N_LOG2 = 4,
  parameter int STAGE  = 0,
  parameter int TW_AW  = N_LOG2 - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  r2mdc_stage_ctrl_if.slave bus
);

  localparam int NPAIR = 1 << (N_LOG2 - 1);
  localparam int CW    = N_LOG2 - 1;
  // butterfly span and commutator delay for this stage
  localparam int D     = (1 << N_LOG2) >> (STAGE + 1);
  localparam int DC    = (STAGE >= N_LOG2 - 1) ? 0 : ((1 << N_LOG2) >> (STAGE + 2));
  localparam int FW    = (DC > 0) ? $clog2(DC + 1) : 1;
  localparam int PW    = (DC > 1) ? $clog2(DC) : 1;

  localparam logic [CW-1:0] D_MASK    = CW'(D - 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NPAIR - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DC);
  localparam logic [PW-1:0] PH_LAST   = PW'((DC > 0) ? DC - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;     // index of the next expected pair
  logic [CW-1:0] ocnt;    // output pair counter
  logic [FW-1:0] fill;    // delay-line occupancy, saturates at DC
  logic [PW-1:0] fcnt;    // flush cycles done
  logic [PW-1:0] pcnt;    // shifts done in the current commutator phase
  logic          sel;     // commutator phase for the next shift

  logic          restart;
  logic          acc;
  logic          flush_cyc;
  logic          ev;
  logic          err;
  logic          last_pair;
  logic          full;
  logic          sel_cur;
  logic [PW-1:0] pcnt_cur;
  logic [CW-1:0] pair_idx;
  logic [TW_AW-1:0] tw_nxt;

  // A start strobe is honoured in every state; outside RUN nothing else is.
  assign restart   = bus.in_valid & bus.in_start;
  assign acc       = bus.in_valid & ((state == RUN) | bus.in_start);
  // A start arriving during FLUSH takes over: its pair shifts the residue out.
  assign flush_cyc = (state == FLUSH) & ~restart;
  assign ev        = acc | flush_cyc;
  assign err       = (state == RUN) & restart & (cnt != '0);
  assign pair_idx  = restart ? '0 : cnt;
  assign last_pair = acc & (pair_idx == LAST_IDX);
  assign full      = (fill == FILL_FULL);
  // Commutator phase realigns to 0 on every frame start.
  assign sel_cur   = restart ? 1'b0 : sel;
  assign pcnt_cur  = restart ? '0 : pcnt;
  // D is a power of two, so cnt mod D is a mask.
  assign tw_nxt    = TW_AW'({{TW_AW{1'b0}}, pair_idx & D_MASK} << STAGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ocnt          <= '0;
      fill          <= '0;
      fcnt          <= '0;
      pcnt          <= '0;
      sel           <= 1'b0;
      bus.tw_addr   <= '0;
      bus.dl_en     <= 1'b0;
      bus.sw_sel    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_start <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.dl_en     <= ev;
      bus.out_valid <= ev & full;
      bus.out_start <= ev & full & (ocnt == '0);
      bus.out_last  <= ev & full & (ocnt == LAST_IDX);
      bus.frame_err <= err;

      if (ev & full) begin
        ocnt <= (ocnt == LAST_IDX) ? '0 : ocnt + CW'(1);
      end

      if (ev) begin
        if (DC > 0) begin
          bus.sw_sel <= sel_cur;
          if (pcnt_cur == PH_LAST) begin
            pcnt <= '0;
            sel  <= ~sel_cur;
          end else begin
            pcnt <= pcnt_cur + PW'(1);
            sel  <= sel_cur;
          end
          if (!full) begin
            fill <= fill + FW'(1);
          end
        end else begin
          bus.sw_sel <= 1'b0;
        end
      end

      if (acc) begin
        bus.tw_addr <= tw_nxt;
        fcnt        <= '0;
        if (last_pair) begin
          cnt      <= '0;
          state    <= (DC > 0) ? FLUSH : IDLE;
          bus.busy <= 1'(DC > 0);
        end else begin
          cnt      <= pair_idx + CW'(1);
          state    <= RUN;
          bus.busy <= 1'b1;
        end
      end else if (flush_cyc) begin
        if (fcnt == PH_LAST) begin
          // delay line is empty again once the last zero has been pushed
          state    <= IDLE;
          bus.busy <= 1'b0;
          fill     <= '0;
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_r2mdc_stage_ctrl.sv
// Bench for r2mdc_stage_ctrl: stages 0, 1 and 3 of a 16-point FFT share one pair stream.
// A frame-level model queues the expected outputs of every delay-line shift; a
// negedge monitor pops and compares them and checks quiet/hold/reset behaviour.
module tb_r2mdc_stage_ctrl;

  localparam int NI = 3;
  localparam int NL = 4;
  localparam int NP = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  typedef struct packed {
    logic [2:0] tw;
    logic       sw;
    logic       ov;
    logic       os;
    logic       ol;
    logic       ferr;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_start;

  logic [NI-1:0] o_dl_en, o_sw, o_ov, o_os, o_ol, o_busy, o_ferr;
  logic [2:0]    o_tw [NI];

  exp_t exp_q [NI][$];

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;
  bit mon_done = 1'b0;

  // reference model state, per instance
  int         m_mode [NI];
  int         m_pidx [NI];
  int         m_ev   [NI];
  int         m_tot  [NI];
  int         m_nout [NI];
  int         m_fl   [NI];
  logic [2:0] m_tw   [NI];

  // monitor history for hold checks
  logic [2:0]    p_tw [NI];
  logic [NI-1:0] p_sw;

  always #5 clk = ~clk;

  function automatic int stage_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_st
    localparam int S = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    r2mdc_stage_ctrl_if #(.TW_AW(NL - 1)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.in_start = in_start;
    r2mdc_stage_ctrl #(.N_LOG2(NL), .STAGE(S), .TW_AW(NL - 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign o_tw[g]    = bus.tw_addr;
    assign o_dl_en[g] = bus.dl_en;
    assign o_sw[g]    = bus.sw_sel;
    assign o_ov[g]    = bus.out_valid;
    assign o_os[g]    = bus.out_start;
    assign o_ol[g]    = bus.out_last;
    assign o_busy[g]  = bus.busy;
    assign o_ferr[g]  = bus.frame_err;
  end

  // Frame-level reference: pair index, shifts since frame start, shifts since the
  // delay line was last empty, and total outputs give every strobe arithmetically.
  task automatic model_step(input int i, input logic v, input logic s);
    int   st;
    int   d;
    int   dc;
    bit   acc;
    bit   fcyc;
    exp_t e;
    st   = stage_of(i);
    d    = (1 << NL) >> (st + 1);
    dc   = (1 << NL) >> (st + 2);
    acc  = v && (m_mode[i] == M_RUN || s);
    fcyc = (m_mode[i] == M_FLUSH) && !(v && s);
    if (!acc && !fcyc) return;
    e = '0;
    if (acc) begin
      e.ferr = (m_mode[i] == M_RUN) && s && (m_pidx[i] != 0);
      if (s) begin
        m_pidx[i] = 0;
        m_ev[i]   = 0;
      end
      m_tw[i] = 3'((m_pidx[i] % d) << st);
    end
    e.tw = m_tw[i];
    e.sw = (dc == 0) ? 1'b0 : 1'((m_ev[i] / dc) % 2);
    e.ov = (m_tot[i] >= dc);
    e.os = e.ov && (m_nout[i] % NP == 0);
    e.ol = e.ov && (m_nout[i] % NP == NP - 1);
    m_ev[i]++;
    m_tot[i]++;
    if (e.ov) m_nout[i]++;
    if (acc) begin
      m_pidx[i]++;
      if (m_pidx[i] == NP) begin
        m_pidx[i] = 0;
        m_mode[i] = (dc > 0) ? M_FLUSH : M_IDLE;
        m_fl[i]   = dc;
      end else begin
        m_mode[i] = M_RUN;
      end
    end else begin
      m_fl[i]--;
      if (m_fl[i] == 0) begin
        m_mode[i] = M_IDLE;
        m_tot[i]  = 0;
      end
    end
    e.busy = (m_mode[i] != M_IDLE);
    exp_q[i].push_back(e);
  endtask

  // model: samples the same inputs the DUTs register, pushes expectations
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_mode[i] = M_IDLE;
          m_pidx[i] = 0;
          m_ev[i]   = 0;
          m_tot[i]  = 0;
          m_nout[i] = 0;
          m_fl[i]   = 0;
          m_tw[i]   = '0;
        end else begin
          model_step(i, in_valid, in_start);
        end
      end
    end
  end

  // monitor: pops on every delay-line shift, checks quiet and hold cycles
  initial begin
    exp_t got;
    exp_t want;
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        got = {o_tw[i], o_sw[i], o_ov[i], o_os[i], o_ol[i], o_ferr[i], o_busy[i]};
        if (!rst_n) begin
          exp_q[i].delete();
          checks++;
          if (got !== '0 || o_dl_en[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero stage%0d t=%0t got dl_en=%b outs=%h required all 0",
                     stage_of(i), $time, o_dl_en[i], got);
          end
        end else if (o_dl_en[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL extra_shift stage%0d t=%0t got dl_en=1 required no shift", stage_of(i), $time);
          end else begin
            want = exp_q[i].pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL shift stage%0d t=%0t got tw=%0d sw=%b ov=%b os=%b ol=%b ferr=%b busy=%b required tw=%0d sw=%b ov=%b os=%b ol=%b ferr=%b busy=%b",
                       stage_of(i), $time, got.tw, got.sw, got.ov, got.os, got.ol, got.ferr, got.busy,
                       want.tw, want.sw, want.ov, want.os, want.ol, want.ferr, want.busy);
            end
          end
        end else begin
          checks++;
          if ({o_ov[i], o_os[i], o_ol[i], o_ferr[i]} !== 4'b0000) begin
            errors++;
            $display("FAIL quiet stage%0d t=%0t got ov/os/ol/ferr=%b%b%b%b required 0000",
                     stage_of(i), $time, o_ov[i], o_os[i], o_ol[i], o_ferr[i]);
          end
          if (o_busy[i]) begin
            checks++;
            if (o_tw[i] !== p_tw[i] || o_sw[i] !== p_sw[i]) begin
              errors++;
              $display("FAIL stall_hold stage%0d t=%0t got tw=%0d sw=%b required tw=%0d sw=%b",
                       stage_of(i), $time, o_tw[i], o_sw[i], p_tw[i], p_sw[i]);
            end
          end
        end
        p_tw[i] = o_tw[i];
        p_sw[i] = o_sw[i];
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_shift stage%0d got %0d unconsumed required 0", stage_of(i), exp_q[i].size());
      end
    end
    mon_done = 1'b1;
  end

  task automatic cyc(input logic v, input logic s);
    in_valid = v;
    in_start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic frame(input int stall_at, input int stall_len);
    for (int p = 0; p < NP; p++) begin
      if (p == stall_at) idle(stall_len);
      cyc(1'b1, p == 0);
    end
  endtask

  initial begin
    logic v;
    logic s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    frame(-1, 0); idle(8);                     // single frame
    frame(3, 3);  idle(8);                     // 3-cycle stall before the 4th pair
    frame(-1, 0); frame(-1, 0); idle(8);       // seamless back-to-back frames
    for (int p = 0; p < 5; p++) cyc(1'b1, p == 0);
    frame(-1, 0); idle(8);                     // restart at cnt=5
    frame(-1, 0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); idle(6);  // stray pairs during flush
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1); idle(2);               // ignored while idle
    frame(-1, 0); idle(2); frame(-1, 0); idle(8);            // start mid-flush
    frame(-1, 0); idle(2);                                   // reset mid-flush
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      v = ($urandom_range(0, 99) < 75);
      s = ($urandom_range(0, 99) < 8);
      cyc(v, s);
    end
    idle(12);

    done = 1'b1;
    wait (mon_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
